// File: rtl/shift_idex_stage.sv
// ID/EX pipeline register with RS/RT operand forwarding feeding the 16-bit left shifter.
// Also keeps a saturating count of issued shift instructions.
module shift_idex_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int SHAMT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic               id_is_shift,
    input  logic               id_regwrite,
    input  logic [REG_AW-1:0]  id_rs_addr,
    input  logic [REG_AW-1:0]  id_rt_addr,
    input  logic [REG_AW-1:0]  id_rd_addr,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [SHAMT_W-1:0] id_imm_shamt,
    input  logic               id_shamt_sel,
    input  logic               exmem_regwrite,
    input  logic [REG_AW-1:0]  exmem_rd,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_regwrite,
    input  logic [REG_AW-1:0]  memwb_rd,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic [REG_AW-1:0]  ex_rd_addr,
    output logic [DATA_W-1:0]  ex_data_in,
    output logic [SHAMT_W-1:0] ex_shamt,
    output logic [1:0]         ex_fwd_a,
    output logic [1:0]         ex_fwd_b,
    output logic [CNT_W-1:0]   shift_count
);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               valid_q;
    logic               regwrite_q;
    logic [REG_AW-1:0]  rs_addr_q;
    logic [REG_AW-1:0]  rt_addr_q;
    logic [REG_AW-1:0]  rd_addr_q;
    logic [DATA_W-1:0]  rs_data_q;
    logic [DATA_W-1:0]  rt_data_q;
    logic [SHAMT_W-1:0] imm_shamt_q;
    logic               shamt_sel_q;
    logic [CNT_W-1:0]   count_q;

    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  rt_val;
    logic [1:0]         rs_src;
    logic [1:0]         rt_src;
    logic               unused_rt_hi;

    // Flush inserts a bubble and outranks stall; reset outranks both.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_shamt_q <= '0;
            shamt_sel_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= id_valid;
            regwrite_q  <= id_regwrite;
            rs_addr_q   <= id_rs_addr;
            rt_addr_q   <= id_rt_addr;
            rd_addr_q   <= id_rd_addr;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_shamt_q <= id_imm_shamt;
            shamt_sel_q <= id_shamt_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (!flush && !stall && id_valid && id_is_shift && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_ONE;
        end
    end

    // EX/MEM is the younger producer, so it is checked before MEM/WB; r0 never forwards.
    always_comb begin
        rs_val = rs_data_q;
        rs_src = FWD_RF;
        if (rs_addr_q == '0) begin
            rs_val = '0;
        end else if (exmem_regwrite && (exmem_rd == rs_addr_q)) begin
            rs_val = exmem_result;
            rs_src = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd == rs_addr_q)) begin
            rs_val = memwb_result;
            rs_src = FWD_MEMWB;
        end

        rt_val = rt_data_q;
        rt_src = FWD_RF;
        if (rt_addr_q == '0) begin
            rt_val = '0;
        end else if (exmem_regwrite && (exmem_rd == rt_addr_q)) begin
            rt_val = exmem_result;
            rt_src = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd == rt_addr_q)) begin
            rt_val = memwb_result;
            rt_src = FWD_MEMWB;
        end
    end

    assign unused_rt_hi = ^rt_val[DATA_W-1:SHAMT_W];

    always_comb begin
        ex_data_in  = '0;
        ex_shamt    = '0;
        ex_regwrite = 1'b0;
        ex_fwd_a    = FWD_RF;
        ex_fwd_b    = FWD_RF;
        if (valid_q) begin
            ex_data_in  = rs_val;
            ex_shamt    = shamt_sel_q ? rt_val[SHAMT_W-1:0] : imm_shamt_q;
            ex_regwrite = regwrite_q;
            ex_fwd_a    = rs_src;
            ex_fwd_b    = rt_src;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_rd_addr  = rd_addr_q;
    assign shift_count = count_q;

endmodule

// File: tb/tb_shift_idex_stage.sv
// Self-checking bench for shift_idex_stage: hand vectors, corner sequences and a
// randomized run against an instruction-level reference model.
module tb_shift_idex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic        id_is_shift;
    logic        id_regwrite;
    logic [2:0]  id_rs_addr;
    logic [2:0]  id_rt_addr;
    logic [2:0]  id_rd_addr;
    logic [15:0] id_rs_data;
    logic [15:0] id_rt_data;
    logic [3:0]  id_imm_shamt;
    logic        id_shamt_sel;
    logic        exmem_regwrite;
    logic [2:0]  exmem_rd;
    logic [15:0] exmem_result;
    logic        memwb_regwrite;
    logic [2:0]  memwb_rd;
    logic [15:0] memwb_result;
    logic        ex_valid;
    logic        ex_regwrite;
    logic [2:0]  ex_rd_addr;
    logic [15:0] ex_data_in;
    logic [3:0]  ex_shamt;
    logic [1:0]  ex_fwd_a;
    logic [1:0]  ex_fwd_b;
    logic [15:0] shift_count;

    int compared   = 0;
    int mismatched = 0;

    shift_idex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_is_shift(id_is_shift), .id_regwrite(id_regwrite),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm_shamt(id_imm_shamt), .id_shamt_sel(id_shamt_sel),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_rd_addr(ex_rd_addr),
        .ex_data_in(ex_data_in), .ex_shamt(ex_shamt),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    // The instruction currently held in EX, as the model sees it.
    typedef struct {
        logic        valid;
        logic        regwrite;
        logic [2:0]  rs, rt, rd;
        logic [15:0] rs_data, rt_data;
        logic [3:0]  imm;
        logic        sel;
    } inst_t;

    typedef struct {
        logic        valid, regwrite, is_shift, sel;
        logic [2:0]  rs, rt, rd;
        logic [15:0] rs_data, rt_data;
        logic [3:0]  imm;
        logic        xw;
        logic [2:0]  xrd;
        logic [15:0] xres;
        logic        ww;
        logic [2:0]  wrd;
        logic [15:0] wres;
        logic [15:0] e_data;
        logic [3:0]  e_shamt;
        logic [1:0]  e_fa, e_fb;
    } vec_t;

    inst_t m_inst;
    int    m_count;
    vec_t  vecs[8];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst || flush) begin
            m_inst = '{default: '0};
        end else if (!stall) begin
            m_inst = '{id_valid, id_regwrite, id_rs_addr, id_rt_addr, id_rd_addr,
                       id_rs_data, id_rt_data, id_imm_shamt, id_shamt_sel};
        end
        if (rst) m_count = 0;
        else if (!flush && !stall && id_valid && id_is_shift) m_count = (m_count + 1 > 65535) ? 65535 : m_count + 1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Newest writer of a register supplies its value; r0 always reads as zero.
    function automatic void resolve(input logic [2:0] a, input logic [15:0] rf,
                                    output logic [15:0] v, output logic [1:0] src);
        v = rf; src = 2'b00;
        if (a == 3'd0) v = 16'h0;
        else if (exmem_regwrite && exmem_rd == a) begin v = exmem_result; src = 2'b10; end
        else if (memwb_regwrite && memwb_rd == a) begin v = memwb_result; src = 2'b01; end
    endfunction

    task automatic checkModel(input string tag);
        logic [15:0] va, vb;
        logic [1:0]  sa, sb;
        int          amt;
        resolve(m_inst.rs, m_inst.rs_data, va, sa);
        resolve(m_inst.rt, m_inst.rt_data, vb, sb);
        amt = m_inst.sel ? (int'(vb) % 16) : int'(m_inst.imm);
        if (!m_inst.valid) begin va = 0; sa = 0; sb = 0; amt = 0; end
        checkOutput({tag, ".valid"},    {15'd0, ex_valid},    {15'd0, m_inst.valid});
        checkOutput({tag, ".regwrite"}, {15'd0, ex_regwrite}, {15'd0, m_inst.valid & m_inst.regwrite});
        checkOutput({tag, ".rd"},       {13'd0, ex_rd_addr},  {13'd0, m_inst.rd});
        checkOutput({tag, ".data"},     ex_data_in,           va);
        checkOutput({tag, ".shamt"},    {12'd0, ex_shamt},    amt[15:0]);
        checkOutput({tag, ".fwd_a"},    {14'd0, ex_fwd_a},    {14'd0, sa});
        checkOutput({tag, ".fwd_b"},    {14'd0, ex_fwd_b},    {14'd0, sb});
        checkOutput({tag, ".count"},    shift_count,          m_count[15:0]);
    endtask

    task automatic applyStimulus(input vec_t v);
        id_valid = v.valid; id_regwrite = v.regwrite; id_is_shift = v.is_shift; id_shamt_sel = v.sel;
        id_rs_addr = v.rs; id_rt_addr = v.rt; id_rd_addr = v.rd;
        id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm_shamt = v.imm;
        exmem_regwrite = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
        memwb_regwrite = v.ww; memwb_rd = v.wrd; memwb_result = v.wres;
        tick();
    endtask

    task automatic randomize_fwd();
        exmem_regwrite = 1'($urandom); exmem_rd = 3'($urandom); exmem_result = 16'($urandom);
        memwb_regwrite = 1'($urandom); memwb_rd = 3'($urandom); memwb_result = 16'($urandom);
    endtask

    task automatic randomize_id();
        id_valid = ($urandom % 4) != 0; id_is_shift = 1'($urandom); id_regwrite = 1'($urandom);
        id_rs_addr = 3'($urandom); id_rt_addr = 3'($urandom); id_rd_addr = 3'($urandom);
        id_rs_data = 16'($urandom); id_rt_data = 16'($urandom);
        id_imm_shamt = 4'($urandom); id_shamt_sel = 1'($urandom);
    endtask

    initial begin
        m_inst = '{default: '0};
        m_count = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b1; id_is_shift = 1'b1; id_regwrite = 1'b1;
        id_rs_addr = 3'd2; id_rt_addr = 3'd3; id_rd_addr = 3'd4;
        id_rs_data = 16'h1234; id_rt_data = 16'h0005; id_imm_shamt = 4'd7; id_shamt_sel = 1'b0;
        exmem_regwrite = 1'b0; exmem_rd = 3'd0; exmem_result = 16'h0;
        memwb_regwrite = 1'b0; memwb_rd = 3'd0; memwb_result = 16'h0;

        vecs[0] = '{1'b1,1'b1,1'b1,1'b0, 3'd2,3'd1,3'd5, 16'h00F1,16'h0000,4'd4, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h00F1,4'd4,2'b00,2'b00};
        vecs[1] = '{1'b1,1'b1,1'b1,1'b0, 3'd3,3'd6,3'd5, 16'h1234,16'h0000,4'd2, 1'b1,3'd3,16'hAAAA, 1'b1,3'd3,16'h5555, 16'hAAAA,4'd2,2'b10,2'b00};
        vecs[2] = '{1'b1,1'b1,1'b1,1'b0, 3'd3,3'd6,3'd5, 16'h1234,16'h0000,4'd2, 1'b0,3'd3,16'hAAAA, 1'b1,3'd3,16'h5555, 16'h5555,4'd2,2'b01,2'b00};
        vecs[3] = '{1'b1,1'b1,1'b1,1'b1, 3'd1,3'd4,3'd7, 16'h0001,16'h0000,4'd9, 1'b0,3'd0,16'h0000, 1'b1,3'd4,16'h0013, 16'h0001,4'd3,2'b00,2'b01};
        vecs[4] = '{1'b1,1'b0,1'b1,1'b1, 3'd2,3'd0,3'd7, 16'h0042,16'h0007,4'd9, 1'b0,3'd0,16'h0000, 1'b1,3'd0,16'h0013, 16'h0042,4'd0,2'b00,2'b00};
        vecs[5] = '{1'b1,1'b1,1'b0,1'b0, 3'd0,3'd2,3'd1, 16'hBEEF,16'h0000,4'd6, 1'b1,3'd0,16'h1111, 1'b1,3'd0,16'h2222, 16'h0000,4'd6,2'b00,2'b00};
        vecs[6] = '{1'b1,1'b1,1'b1,1'b1, 3'd6,3'd5,3'd2, 16'h0F0F,16'h0003,4'd0, 1'b1,3'd5,16'hFFF7, 1'b1,3'd6,16'h8080, 16'h8080,4'd7,2'b01,2'b10};
        vecs[7] = '{1'b0,1'b1,1'b1,1'b1, 3'd3,3'd3,3'd3, 16'h1111,16'h2222,4'd5, 1'b1,3'd3,16'hAAAA, 1'b1,3'd3,16'h5555, 16'h0000,4'd0,2'b00,2'b00};

        // Reset held two cycles while decode presents a live shift.
        tick(); tick();
        checkOutput("reset.valid", {15'd0, ex_valid}, 16'h0);
        checkOutput("reset.regwrite", {15'd0, ex_regwrite}, 16'h0);
        checkOutput("reset.rd", {13'd0, ex_rd_addr}, 16'h0);
        checkOutput("reset.data", ex_data_in, 16'h0);
        checkOutput("reset.shamt", {12'd0, ex_shamt}, 16'h0);
        checkOutput("reset.fwd", {12'd0, ex_fwd_a, ex_fwd_b}, 16'h0);
        checkOutput("reset.count", shift_count, 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d.valid", i), {15'd0, ex_valid}, {15'd0, vecs[i].valid});
            checkOutput($sformatf("vec%0d.regwrite", i), {15'd0, ex_regwrite}, {15'd0, vecs[i].valid & vecs[i].regwrite});
            checkOutput($sformatf("vec%0d.data", i), ex_data_in, vecs[i].e_data);
            checkOutput($sformatf("vec%0d.shamt", i), {12'd0, ex_shamt}, {12'd0, vecs[i].e_shamt});
            checkOutput($sformatf("vec%0d.fwd_a", i), {14'd0, ex_fwd_a}, {14'd0, vecs[i].e_fa});
            checkOutput($sformatf("vec%0d.fwd_b", i), {14'd0, ex_fwd_b}, {14'd0, vecs[i].e_fb});
            checkModel($sformatf("vec%0d.model", i));
        end
        // vecs 0,1,2,3,4,6 were valid shifts.
        checkOutput("vec.count", shift_count, 16'd6);

        // Hold instruction A through a three-cycle stall while decode keeps changing.
        applyStimulus('{1'b1,1'b1,1'b1,1'b0, 3'd2,3'd0,3'd6, 16'h1357,16'h0000,4'd5, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 16'h0,4'd0,2'b00,2'b00});
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            tick();
        end
        checkOutput("stall.data", ex_data_in, 16'h1357);
        checkOutput("stall.shamt", {12'd0, ex_shamt}, 16'd5);
        checkOutput("stall.rd", {13'd0, ex_rd_addr}, 16'd6);
        checkOutput("stall.count", shift_count, 16'd7);
        exmem_regwrite = 1'b1; exmem_rd = 3'd2; exmem_result = 16'hC0DE;
        #1;
        checkOutput("stall.refwd", ex_data_in, 16'hC0DE);
        checkModel("stall.model");
        flush = 1'b1;
        tick();
        checkOutput("flush.valid", {15'd0, ex_valid}, 16'h0);
        checkOutput("flush.regwrite", {15'd0, ex_regwrite}, 16'h0);
        checkOutput("flush.data", ex_data_in, 16'h0);
        checkOutput("flush.count", shift_count, 16'd7);
        stall = 1'b0; flush = 1'b0;

        // Randomized run with comb re-evaluation of forwarding between edges.
        for (int i = 0; i < 2000; i++) begin
            randomize_id();
            randomize_fwd();
            stall = ($urandom % 6) == 0;
            flush = ($urandom % 9) == 0;
            rst   = ($urandom % 97) == 0;
            tick();
            checkModel("rand");
            randomize_fwd();
            #1;
            checkModel("rand.refwd");
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        // Drive the counter to saturation, push once more, then reset it.
        rst = 1'b1; tick(); rst = 1'b0;
        id_valid = 1'b1; id_is_shift = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        checkOutput("sat.full", shift_count, 16'hFFFF);
        tick();
        checkOutput("sat.hold", shift_count, 16'hFFFF);
        rst = 1'b1; tick();
        checkOutput("sat.reset", shift_count, 16'h0000);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_idex_stage.md
Name: shift_idex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the 16-bit combinational left shifter in the execute stage.
- Captures decoded shift instructions and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the shifter's data operand and 4-bit shift amount.
- Keeps a saturating count of issued shift operations for performance monitoring.

Parameters:
DATA_W, 16, operand/result width
REG_AW, 3, register address width (8 GPRs, r0 hardwired zero)
SHAMT_W, 4, shift-amount width (equals log2(DATA_W))
CNT_W, 16, width of issued-shift counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall  in  1  hold current stage contents
flush  in  1  replace captured instruction with bubble
id_valid  in  1  decode stage presents an instruction
id_is_shift  in  1  instruction is a left shift (counts toward perf counter)
id_regwrite  in  1  instruction writes rd
id_rs_addr  in  REG_AW  source register of data operand
id_rt_addr  in  REG_AW  source register for register-form shift amount
id_rd_addr  in  REG_AW  destination register
id_rs_data  in  DATA_W  register-file value of rs
id_rt_data  in  DATA_W  register-file value of rt
id_imm_shamt  in  SHAMT_W  immediate shift amount
id_shamt_sel  in  1  0 = immediate shamt, 1 = rt[SHAMT_W-1:0]
exmem_regwrite  in  1  EX/MEM instruction writes a register
exmem_rd  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM result
memwb_regwrite  in  1  MEM/WB instruction writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB result
ex_valid  out  1  execute stage holds a live instruction
ex_regwrite  out  1  registered regwrite, gated by ex_valid
ex_rd_addr  out  REG_AW  registered destination
ex_data_in  out  DATA_W  forwarded data operand to shifter
ex_shamt  out  SHAMT_W  resolved shift amount to shifter
ex_fwd_a  out  2  rs forward source: 00 regfile, 01 MEM/WB, 10 EX/MEM
ex_fwd_b  out  2  rt forward source, same encoding
shift_count  out  CNT_W  number of valid shifts issued, saturating

Behaviour:
- Reset (rst=1 at clk edge): all stage registers cleared; ex_valid=0, ex_regwrite=0, ex_rd_addr=0, ex_data_in=0, ex_shamt=0, ex_fwd_a=ex_fwd_b=00, shift_count=0. Reset overrides stall and flush.
- Capture: when not stalled and not flushed, each edge loads all id_* fields; latency is 1 cycle from ID inputs to registered fields.
- Stall=1, flush=0: all registers hold. Forwarded outputs still re-evaluate against current exmem/memwb inputs.
- Flush=1: next state is a bubble (valid=0, regwrite=0, other fields 0). Flush takes priority over stall.
- Forwarding is combinational on registered addresses/data (outputs valid in the same cycle as the forwarding inputs). Per operand X in {rs, rt}:
  - EX/MEM forward if exmem_regwrite and exmem_rd==X_addr and X_addr!=0.
  - Otherwise MEM/WB forward if memwb_regwrite and memwb_rd==X_addr and X_addr!=0.
  - Otherwise the registered regfile value.
  - EX/MEM wins when both match.
  - X_addr==0 always yields 0, regardless of the regfile value.
- ex_shamt = registered imm_shamt when shamt_sel=0; otherwise the forwarded rt value [SHAMT_W-1:0]. Upper rt bits are ignored, so rt=0x0013 gives shamt 3.
- When ex_valid=0: ex_data_in, ex_shamt, ex_regwrite and ex_fwd_* are driven to 0.
- shift_count increments by 1 on each edge where a valid, non-flushed, non-stalled instruction with id_is_shift=1 is captured. It saturates at all-ones (no wrap). It holds during stall and flush.

Test Plan:
- Reset then idle: assert rst 2 cycles with id_valid=1 → ex_valid=0, all outputs 0, shift_count=0.
- Immediate shift, no hazard: rs=r2 (0x00F1), imm_shamt=4, sel=0 → next cycle ex_data_in=0x00F1, ex_shamt=4, ex_fwd_a=00, shift_count=1.
- Double hazard priority: rs=r3; exmem writes r3=0xAAAA, memwb writes r3=0x5555 → ex_data_in=0xAAAA, ex_fwd_a=10. Drop exmem_regwrite → 0x5555, fwd_a=01.
- Register shamt with forwarding on rt: sel=1, rt=r4, regfile 0x0000, memwb writes r4=0x0013 → ex_shamt=3, ex_fwd_b=01. Same with rt=r0 and memwb_rd=0 → ex_shamt=0, fwd_b=00.
- Stall/flush interaction: capture instr A, stall 3 cycles while changing id_* → outputs retain A and count unchanged. Assert stall and flush together → ex_valid=0, ex_regwrite=0.
- Counter saturation: preload via 0xFFFF issued shifts (or force) then issue another → shift_count stays 0xFFFF. Reset mid-stream → 0 next edge.
